// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: FSM state encoding, reset vector default and
// the instruction size used for sequential PC advance.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD
    } fetch_state_e;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
    localparam logic [2:0]  INSTR_BYTES      = 3'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} queue between instruction memory and decode.
// Flush wins over push/pop; simultaneous push and pop keeps count and order.
module fetch_fifo #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_instr,
    output logic [XLEN-1:0] head_pc,
    output logic [31:0]     head_instr,
    output logic [1:0]      count
);

    logic [XLEN-1:0] pc_mem    [2];
    logic [31:0]     instr_mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_mem[0]    <= '0;
            pc_mem[1]    <= '0;
            instr_mem[0] <= '0;
            instr_mem[1] <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests, buffers responses in a 2-entry
// queue for decode, and handles redirects including in-flight responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] hold_addr_q;
    logic [XLEN-1:0] hold_addr_d;
    logic [XLEN-1:0] redirect_target;
    logic            pending_q;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    logic            redirect_pc_unused;

    // Low address bits of a redirect are architecturally ignored.
    assign redirect_target    = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_pc_unused = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            hold_addr_q <= RESET_PC;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_addr_q <= hold_addr_d;
            pending_q   <= imem_req && !imem_ack;
        end
    end

    // Request depends only on registered state, never on the returned data.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_addr_d = hold_addr_q;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) begin
                    pc_d = redirect_target;
                end
            end
            FETCH: begin
                imem_req = (count != 2'd2) || pending_q;
                if (redirect) begin
                    pc_d = redirect_target;
                    if (imem_req && !imem_ack) begin
                        // The unaccepted request must stay on the bus until acked.
                        state_d     = DISCARD;
                        hold_addr_d = pc_q;
                    end
                end else if (imem_req && imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + XLEN'(INSTR_BYTES);
                end
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = hold_addr_q;
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_valid = (count != 2'd0) && !redirect;
    assign pop         = instr_valid && instr_ready;

    fetch_fifo #(
        .XLEN(XLEN)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_pc    (pc_q),
        .push_instr (imem_rdata),
        .head_pc    (instr_pc),
        .head_instr (instr),
        .count      (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [31:0] salt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    fetch_unit #(
        .XLEN     (64),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word derived from the requested address.
    assign imem_rdata = imem_addr[31:0] ^ 32'h1357_0000 ^ salt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: program counter, fetch queue contents, and whether an
    // old request is still being waited out after a redirect.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc    = RST_PC;
    logic [63:0] m_hold  = RST_PC;
    bit          m_idle  = 1'b1;
    bit          m_disc  = 1'b0;
    bit          m_out   = 1'b0;

    always @(negedge clk) begin
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        if (!reset_n) begin
            chk("rst_req", imem_req, 1'b0);
            chk("rst_valid", instr_valid, 1'b0);
            chk("rst_addr", imem_addr, RST_PC);
            chk("rst_instr", instr, 64'h0);
            chk("rst_instr_pc", instr_pc, 64'h0);
            m_q.delete();
            m_pc   = RST_PC;
            m_idle = 1'b1;
            m_disc = 1'b0;
            m_out  = 1'b0;
        end else begin
            if (m_idle)      e_req = 1'b0;
            else if (m_disc) e_req = 1'b1;
            else             e_req = (m_q.size() < 2) || m_out;
            e_addr  = m_disc ? m_hold : m_pc;
            e_valid = (m_q.size() != 0) && !redirect;
            chk("req", imem_req, e_req);
            chk("addr", imem_addr, e_addr);
            chk("valid", instr_valid, e_valid);
            if (e_valid) begin
                chk("instr", instr, m_q[0].w);
                chk("instr_pc", instr_pc, m_q[0].pc);
            end
            if (m_idle) begin
                m_idle = 1'b0;
                m_out  = 1'b0;
            end else begin
                if (redirect) begin
                    m_q.delete();
                    if (m_disc) begin
                        if (imem_ack) m_disc = 1'b0;
                    end else if (e_req && !imem_ack) begin
                        m_disc = 1'b1;
                        m_hold = m_pc;
                    end
                    m_pc = {redirect_pc[63:2], 2'b00};
                end else if (m_disc) begin
                    if (imem_ack) m_disc = 1'b0;
                end else begin
                    if (e_valid && instr_ready) void'(m_q.pop_front());
                    if (e_req && imem_ack) begin
                        m_q.push_back('{pc: m_pc, w: imem_rdata});
                        m_pc = m_pc + 64'd4;
                    end
                end
                m_out = e_req && !imem_ack;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after release (fetch still idle).
    task automatic do_reset();
        reset_n  = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int hold;
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        salt        = '0;

        // Zero-latency ack streams 0,4,8 with data visible one cycle after ack.
        do_reset();
        #1 chk("d1_idle_req", imem_req, 1'b0);
        step(); imem_ack = 1'b1;
        #1 chk("d1_addr0", imem_addr, 64'h0);
        chk("d1_req", imem_req, 1'b1);
        chk("d1_valid0", instr_valid, 1'b0);
        step();
        #1 chk("d1_addr4", imem_addr, 64'h4);
        chk("d1_valid1", instr_valid, 1'b1);
        chk("d1_pc0", instr_pc, 64'h0);
        chk("d1_word0", instr, 64'h1357_0000);
        step();
        #1 chk("d1_addr8", imem_addr, 64'h8);

        // Stalled decode fills the queue, request drops, resumes at 8.
        do_reset();
        instr_ready = 1'b0;
        step(); imem_ack = 1'b1;
        step();
        step();
        #1 chk("d2_full_req", imem_req, 1'b0);
        chk("d2_head_pc", instr_pc, 64'h0);
        step(); instr_ready = 1'b1;
        #1 chk("d2_still_full", imem_req, 1'b0);
        step();
        #1 chk("d2_req_again", imem_req, 1'b1);
        chk("d2_addr8", imem_addr, 64'h8);
        chk("d2_head_pc4", instr_pc, 64'h4);

        // Redirect to 0x103 while 0x10 is outstanding; ack three cycles later.
        do_reset();
        step(); imem_ack = 1'b1;
        repeat (3) step();
        step(); imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 64'h103;
        #1 chk("d3_addr10", imem_addr, 64'h10);
        chk("d3_valid_redir", instr_valid, 1'b0);
        step(); redirect = 1'b0;
        #1 chk("d3_hold_addr", imem_addr, 64'h10);
        chk("d3_hold_req", imem_req, 1'b1);
        chk("d3_hold_valid", instr_valid, 1'b0);
        step();
        #1 chk("d3_hold_addr2", imem_addr, 64'h10);
        step(); imem_ack = 1'b1;
        #1 chk("d3_ack_addr", imem_addr, 64'h10);
        step(); imem_ack = 1'b0;
        #1 chk("d3_new_addr", imem_addr, 64'h100);
        chk("d3_new_valid", instr_valid, 1'b0);
        step(); imem_ack = 1'b1;
        #1 chk("d3_wait_valid", instr_valid, 1'b0);
        step(); imem_ack = 1'b0;
        #1 chk("d3_valid", instr_valid, 1'b1);
        chk("d3_pc", instr_pc, 64'h100);
        chk("d3_word", instr, 64'h1357_0100);

        // Redirect in the ack cycle drops the word; top-of-space PC wraps to 0.
        step(); imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        step(); redirect = 1'b0;
        #1 chk("d4_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("d4_no_push", instr_valid, 1'b0);
        step();
        #1 chk("d4_wrap", imem_addr, 64'h0);
        chk("d4_valid", instr_valid, 1'b1);
        chk("d4_pc_top", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset during a discarded request clears outputs at once.
        step(); imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 64'h200;
        step(); redirect = 1'b0;
        #1 chk("d5_disc_req", imem_req, 1'b1);
        chk("d5_disc_addr", imem_addr, 64'h4);
        #1 reset_n = 1'b0;
        #1 chk("d5_rst_req", imem_req, 1'b0);
        chk("d5_rst_valid", instr_valid, 1'b0);
        chk("d5_rst_addr", imem_addr, RST_PC);
        imem_ack = 1'b1;
        step();
        step(); reset_n = 1'b1; imem_ack = 1'b0;
        #1 chk("d5_idle_req", imem_req, 1'b0);
        step(); imem_ack = 1'b1;
        #1 chk("d5_first_addr", imem_addr, RST_PC);
        step(); imem_ack = 1'b0;
        #1 chk("d5_first_pc", instr_pc, RST_PC);
        chk("d5_first_valid", instr_valid, 1'b1);

        // Randomized traffic, checked by the per-cycle model.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!reset_n) begin
                redirect = 1'b0;
                imem_ack = 1'b0;
                hold--;
                if (hold <= 0) reset_n = 1'b1;
                continue;
            end
            instr_ready = ($urandom_range(0, 3) != 0);
            imem_ack    = imem_req && ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = {$urandom, $urandom};
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: redirect_pc = 64'($urandom_range(0, 255));
            endcase
            salt = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                #1 reset_n = 1'b0;
                hold = $urandom_range(1, 3);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
